// File: rtl/vai_rx_route.sv
// vai_rx_route: CCI-P Rx return-path router for the virtualized mux.
// Demultiplexes one upstream Rx port to NUM_SUB_AFUS sub-AFU ports plus a manager port
// (index NUM_SUB_AFUS). Responses are steered by the AFU tag in mdata[15:16-TAG_BITS],
// which is stripped on delivery. MMIO requests are steered by address window. Per-port
// outstanding-line counters support per-AFU idle reporting.
// Optional: define VAI_RX_ROUTE_STATS_EN to add rsp_count / drop_count statistics.

package vai_ccip_pkg;
    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    // Same 28 bits as t_ccip_c0_RspMemHdr, reinterpreted for MMIO requests
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

module vai_rx_route
    import vai_ccip_pkg::*;
#(
    parameter int unsigned NUM_SUB_AFUS  = 8,
    parameter int unsigned MMIO_WIN_BITS = 10,
    parameter int unsigned CNT_W         = 10
) (
    input  logic                  pClk,
    input  logic                  SoftReset,
    input  t_if_ccip_Rx           up_RxPort,
    output t_if_ccip_Rx           afu_RxPort     [NUM_SUB_AFUS],
    output t_if_ccip_Rx           mgr_RxPort,
    input  logic [NUM_SUB_AFUS:0] rd_issue_valid,
    input  logic [2:0]            rd_issue_lines [NUM_SUB_AFUS+1],
    input  logic [NUM_SUB_AFUS:0] wr_issue_valid,
    input  logic [2:0]            wr_issue_lines [NUM_SUB_AFUS+1],
    output logic [CNT_W-1:0]      rd_outstanding [NUM_SUB_AFUS+1],
    output logic [CNT_W-1:0]      wr_outstanding [NUM_SUB_AFUS+1],
    output logic [NUM_SUB_AFUS:0] port_idle,
    output logic                  err_bad_tag,
    output logic                  err_underflow
`ifdef VAI_RX_ROUTE_STATS_EN
    ,
    output logic [31:0]           rsp_count      [NUM_SUB_AFUS+1],
    output logic [15:0]           drop_count
`endif
);
    localparam int NSUB     = int'(NUM_SUB_AFUS);
    localparam int NPORTS   = NSUB + 1;
    localparam int TAG_BITS = $clog2(NSUB + 1);
    localparam int TAG_LSB  = 16 - TAG_BITS;
    localparam int WIN_W    = 16 - int'(MMIO_WIN_BITS);
    localparam logic [TAG_BITS-1:0] MGR_TAG  = TAG_BITS'(NSUB);
    localparam logic [WIN_W-1:0]    SUB_WINS = WIN_W'(NSUB);
    // AlmFull bits are the two MSBs of the Rx struct
    localparam t_if_ccip_Rx RX_RST =
        t_if_ccip_Rx'({2'b11, {($bits(t_if_ccip_Rx) - 2){1'b0}}});

    logic [TAG_BITS-1:0] w_c0_tag, w_c1_tag;
    logic                w_c0_bad, w_c1_bad, w_mmio, w_win_sub;
    logic [WIN_W-1:0]    w_win;
    t_ccip_c0_ReqMmioHdr w_mmio_raw, w_mmio_win;
    t_ccip_c0_RspMemHdr  w_c0_hdr_rsp, w_c0_hdr_win;
    t_ccip_c1_RspMemHdr  w_c1_hdr;
    logic [NPORTS-1:0]   w_c0_hit, w_c1_hit, w_mmio_hit;
    t_if_ccip_Rx         w_rx_d [NPORTS];
    t_if_ccip_Rx         r_rx   [NPORTS];

    logic [CNT_W-1:0]    r_rd [NPORTS], r_wr [NPORTS], w_rd_d [NPORTS], w_wr_d [NPORTS];
    logic [NPORTS-1:0]   w_rd_uf, w_wr_uf, r_idle;
    logic [2:0]          w_wr_sub;
    logic                r_err_bad_tag, r_err_underflow;

    // Counter step at CNT_W+1 bits; MSB of the result flags an underflow (value clamped to 0)
    function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic [2:0] add, input logic [2:0] sub);
        logic [CNT_W:0] sum, diff;
        sum = {1'b0, cnt} + {{(CNT_W - 2){1'b0}}, add};
        if (sum < {{(CNT_W - 2){1'b0}}, sub}) return {1'b1, {CNT_W{1'b0}}};
        diff = sum - {{(CNT_W - 2){1'b0}}, sub};
        if (diff[CNT_W]) return {1'b0, {CNT_W{1'b1}}};
        return {1'b0, diff[CNT_W-1:0]};
    endfunction

    // Decode tags and MMIO window, build stripped headers and per-port hit vectors
    always_comb begin
        w_c0_tag     = up_RxPort.c0.hdr.mdata[15:TAG_LSB];
        w_c1_tag     = up_RxPort.c1.hdr.mdata[15:TAG_LSB];
        w_c0_bad     = up_RxPort.c0.rspValid && (w_c0_tag > MGR_TAG);
        w_c1_bad     = up_RxPort.c1.rspValid && (w_c1_tag > MGR_TAG);
        w_mmio       = up_RxPort.c0.mmioRdValid || up_RxPort.c0.mmioWrValid;
        w_mmio_raw   = t_ccip_c0_ReqMmioHdr'(up_RxPort.c0.hdr);
        w_win        = w_mmio_raw.address[15:MMIO_WIN_BITS];
        w_win_sub    = w_win < SUB_WINS;
        w_mmio_win   = w_mmio_raw;
        w_mmio_win.address[15:MMIO_WIN_BITS] = '0;
        w_c0_hdr_win = t_ccip_c0_RspMemHdr'(w_mmio_win);
        w_c0_hdr_rsp = up_RxPort.c0.hdr;
        w_c0_hdr_rsp.mdata[15:TAG_LSB] = '0;
        w_c1_hdr     = up_RxPort.c1.hdr;
        w_c1_hdr.mdata[15:TAG_LSB] = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_c0_hit[p] = up_RxPort.c0.rspValid && (w_c0_tag == TAG_BITS'(p));
            w_c1_hit[p] = up_RxPort.c1.rspValid && (w_c1_tag == TAG_BITS'(p));
            if (p < NSUB) w_mmio_hit[p] = w_mmio && w_win_sub && (w_win == WIN_W'(p));
            else          w_mmio_hit[p] = w_mmio && !w_win_sub;
        end
    end

    // Next-state Rx image per port: broadcast AlmFull/data, per-port header and valids
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_rx_d[p]             = '0;
            w_rx_d[p].c0TxAlmFull = up_RxPort.c0TxAlmFull;
            w_rx_d[p].c1TxAlmFull = up_RxPort.c1TxAlmFull;
            w_rx_d[p].c0.data     = up_RxPort.c0.data;
            if (up_RxPort.c0.rspValid) w_rx_d[p].c0.hdr = w_c0_hdr_rsp;
            else if (p < NSUB)         w_rx_d[p].c0.hdr = w_c0_hdr_win;
            else                       w_rx_d[p].c0.hdr = up_RxPort.c0.hdr;
            w_rx_d[p].c0.rspValid    = w_c0_hit[p];
            w_rx_d[p].c0.mmioRdValid = w_mmio_hit[p] && up_RxPort.c0.mmioRdValid;
            w_rx_d[p].c0.mmioWrValid = w_mmio_hit[p] && up_RxPort.c0.mmioWrValid;
            w_rx_d[p].c1.hdr         = w_c1_hdr;
            w_rx_d[p].c1.rspValid    = w_c1_hit[p];
        end
    end

    // Single register stage for every Rx output
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            for (int p = 0; p < NPORTS; p++) r_rx[p] <= RX_RST;
        end else begin
            r_rx <= w_rx_d;
        end
    end

    // Outstanding counter next-state with clamp/saturate
    always_comb begin
        w_wr_sub = up_RxPort.c1.hdr.format ? {1'b0, up_RxPort.c1.hdr.cl_num} + 3'd1 : 3'd1;
        for (int p = 0; p < NPORTS; p++) begin
            {w_rd_uf[p], w_rd_d[p]} = cnt_next(r_rd[p],
                                               rd_issue_valid[p] ? rd_issue_lines[p] : 3'd0,
                                               w_c0_hit[p] ? 3'd1 : 3'd0);
            {w_wr_uf[p], w_wr_d[p]} = cnt_next(r_wr[p],
                                               wr_issue_valid[p] ? wr_issue_lines[p] : 3'd0,
                                               w_c1_hit[p] ? w_wr_sub : 3'd0);
        end
    end

    // Counters and idle flags; idle uses next-state so it tracks the counters exactly
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rd[p] <= '0;
                r_wr[p] <= '0;
            end
            r_idle <= '1;
        end else begin
            r_rd <= w_rd_d;
            r_wr <= w_wr_d;
            for (int p = 0; p < NPORTS; p++) r_idle[p] <= (w_rd_d[p] == '0) && (w_wr_d[p] == '0);
        end
    end

    // Sticky error flags
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_err_bad_tag   <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_c0_bad || w_c1_bad)   r_err_bad_tag   <= 1'b1;
            if (|{w_rd_uf, w_wr_uf})    r_err_underflow <= 1'b1;
        end
    end

    for (genvar g = 0; g < NSUB; g++) begin : g_afu
        assign afu_RxPort[g] = r_rx[g];
    end
    assign mgr_RxPort     = r_rx[NSUB];
    assign rd_outstanding = r_rd;
    assign wr_outstanding = r_wr;
    assign port_idle      = r_idle;
    assign err_bad_tag    = r_err_bad_tag;
    assign err_underflow  = r_err_underflow;

`ifdef VAI_RX_ROUTE_STATS_EN
    logic [31:0] r_rsp_cnt [NPORTS];
    logic [15:0] r_drop_cnt;
    logic [16:0] w_drop_sum;

    // Drop count sum ahead of saturation
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_c0_bad) + 17'(w_c1_bad);
    end

    // Per-port delivered responses (wrapping) and saturating drop count
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            for (int p = 0; p < NPORTS; p++) r_rsp_cnt[p] <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rsp_cnt[p] <= r_rsp_cnt[p] + 32'(w_c0_hit[p]) + 32'(w_c1_hit[p]);
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign rsp_count  = r_rsp_cnt;
    assign drop_count = r_drop_cnt;
`endif
endmodule
